// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the FSM state enum, requester count, index width and a one-hot decoder.
package rr_arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit of a one-hot vector (OR of indices is exact for one-hot).
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin selector: first set request at ptr, ptr+1, ... (mod 8).
// Produces a one-hot pick and a flag that any request is present.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    // 3-bit addition wraps 7 -> 0 so the scan is naturally circular
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, handshake
// acceptance and a hold timeout that drops grants the downstream never takes.
module rr_arbiter8 #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         timeout
);

  import rr_arb_pkg::*;

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     gnt_q;
  logic             gnt_valid_q;
  logic             timeout_q;

  logic [N-1:0]     pick;
  logic             any_req;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_d;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  assign gnt_idx = onehot_idx(gnt_q);
  assign ptr_d   = gnt_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q       <= pick;
            gnt_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          // Acceptance wins over an expiring hold counter
          if (gnt_ready) begin
            ptr_q       <= ptr_d;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ptr_q       <= ptr_d;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus a randomized run,
// all compared against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       gnt_ready = 1'b0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the grant, for how many cycles it has been shown,
  // where the next search starts, and whether a timeout pulse is visible.
  bit m_busy  = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_shown = 0;
  bit m_to    = 1'b0;

  rr_arbiter8 #(.N(8), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_gnt();
    return m_busy ? 8'(1 << m_idx) : 8'h00;
  endfunction

  task automatic tick(input logic r, input logic [7:0] rq, input logic rdy);
    rst_n = r;
    req = rq;
    gnt_ready = rdy;
    @(posedge clk);
    if (!r) begin
      m_busy = 1'b0; m_ptr = 0; m_shown = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (rq != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (rq[(m_ptr + k) % 8]) begin
              m_idx = (m_ptr + k) % 8;
              break;
            end
          end
          m_busy = 1'b1;
          m_shown = 1;
        end
      end else if (rdy) begin
        m_ptr = (m_idx + 1) % 8;
        m_busy = 1'b0;
      end else if (m_shown == TO) begin
        m_ptr = (m_idx + 1) % 8;
        m_busy = 1'b0;
        m_to = 1'b1;
      end else begin
        m_shown++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'hFF, 1'b1);
      n_cmp++;
      if ({gnt, gnt_valid, timeout} !== 10'h000) begin
        n_err++;
        $display("FAIL reset[%0d]: gnt=%h vld=%b to=%b, expected all zero", i, gnt, gnt_valid, timeout);
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] seq[$];
    for (int c = 0; c < 40 && seq.size() < 9; c++) begin
      tick(1'b1, 8'hFF, m_busy);
      n_cmp++;
      if ({gnt, gnt_valid, timeout} !== {m_gnt(), m_busy, m_to}) begin
        n_err++;
        $display("FAIL rotation: gnt=%h vld=%b to=%b, expected gnt=%h vld=%b to=%b",
                 gnt, gnt_valid, timeout, m_gnt(), m_busy, m_to);
      end
      if (gnt_valid) seq.push_back(gnt);
    end
    n_cmp++;
    if (seq.size() != 9) begin
      n_err++;
      $display("FAIL rotation_count: got %0d grants, expected 9", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      n_cmp++;
      if (seq[k] !== 8'(1 << (k % 8))) begin
        n_err++;
        $display("FAIL rotation_seq[%0d]: gnt=%h, expected %h", k, seq[k], 8'(1 << (k % 8)));
      end
    end
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] t_req[6] = '{8'h20, 8'h00, 8'h81, 8'h81, 8'h81, 8'h00};
    logic       t_rdy[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t_exp[6] = '{8'h20, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
    for (int s = 0; s < 6; s++) begin
      tick(1'b1, t_req[s], t_rdy[s]);
      n_cmp++;
      if (gnt !== t_exp[s] || {gnt, gnt_valid, timeout} !== {m_gnt(), m_busy, m_to}) begin
        n_err++;
        $display("FAIL wrap[%0d]: gnt=%h vld=%b to=%b, expected gnt=%h vld=%b to=%b",
                 s, gnt, gnt_valid, timeout, t_exp[s], m_busy, m_to);
      end
    end
    tick(1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_timeout();
    int held = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(1'b1, 8'h04, 1'b0);
      n_cmp++;
      if ({gnt, gnt_valid, timeout} !== {m_gnt(), m_busy, m_to}) begin
        n_err++;
        $display("FAIL timeout_cycle: gnt=%h vld=%b to=%b, expected gnt=%h vld=%b to=%b",
                 gnt, gnt_valid, timeout, m_gnt(), m_busy, m_to);
      end
      if (timeout) seen = 1'b1;
      else if (gnt == 8'h04) held++;
    end
    n_cmp++;
    if (!seen || held != TO) begin
      n_err++;
      $display("FAIL timeout_len: held %0d cycles (pulse seen=%b), expected %0d with pulse", held, seen, TO);
    end
    n_cmp++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_drop: gnt=%h vld=%b, expected 00/0", gnt, gnt_valid);
    end
    tick(1'b1, 8'h04, 1'b0);
    n_cmp++;
    if (gnt !== 8'h04 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_regrant: gnt=%h to=%b, expected 04/0", gnt, timeout);
    end
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 8'h08, 1'b0);
    for (int c = 0; c < 30 && m_shown < TO; c++) tick(1'b1, 8'h08, 1'b0);
    n_cmp++;
    if (gnt !== 8'h08 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL simul_hold: gnt=%h to=%b, expected 08/0", gnt, timeout);
    end
    tick(1'b1, 8'h08, 1'b1);
    n_cmp++;
    if ({gnt, gnt_valid, timeout} !== 10'h000) begin
      n_err++;
      $display("FAIL simul_accept: gnt=%h vld=%b to=%b, expected 00/0/0", gnt, gnt_valid, timeout);
    end
    tick(1'b1, 8'h00, 1'b0);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL simul_late_pulse: to=%b, expected 0", timeout);
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 8'h10, 1'b0);
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h10, 1'b0);
    n_cmp++;
    if (gnt !== 8'h10) begin
      n_err++;
      $display("FAIL midrst_setup: gnt=%h, expected 10", gnt);
    end
    tick(1'b0, 8'h10, 1'b0);
    n_cmp++;
    if ({gnt, gnt_valid, timeout} !== 10'h000) begin
      n_err++;
      $display("FAIL midrst_abandon: gnt=%h vld=%b to=%b, expected 00/0/0", gnt, gnt_valid, timeout);
    end
    tick(1'b1, 8'h30, 1'b0);
    n_cmp++;
    if (gnt !== 8'h10 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_restart: gnt=%h vld=%b, expected 10/1", gnt, gnt_valid);
    end
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic       r;
    logic [7:0] rq;
    logic       rdy;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) != 0);
      rq  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      tick(r, rq, rdy);
      n_cmp++;
      if ({gnt, gnt_valid, timeout} !== {m_gnt(), m_busy, m_to} || $countones(gnt) > 1) begin
        n_err++;
        $display("FAIL random[%0d]: gnt=%h vld=%b to=%b, expected gnt=%h vld=%b to=%b",
                 c, gnt, gnt_valid, timeout, m_gnt(), m_busy, m_to);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
